// File: rtl/cv32e40p_fault_monitor.sv
// Fault monitor for the cv32e40p fault-tolerance outputs: TMR divider voting,
// saturating error counters, sticky fault logs and an alarm req/ack handshake.
module cv32e40p_fault_monitor #(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned THRESHOLD = 4,
    parameter int unsigned DIV_W     = 33
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic [DIV_W-1:0] div_in_0_i,
    input  logic [DIV_W-1:0] div_in_1_i,
    input  logic [DIV_W-1:0] div_in_2_i,
    input  logic [14:0]      mem_err_i,
    input  logic [2:0]       rf_err_i,
    input  logic             clear_i,
    input  logic             alarm_ack_i,
    output logic [DIV_W-1:0] voted_o,
    output logic             div_mismatch_o,
    output logic [2:0]       faulty_lane_o,
    output logic             div_uncorr_o,
    output logic [CNT_W-1:0] div_corr_cnt_o,
    output logic [CNT_W-1:0] mem_err_cnt_o,
    output logic [CNT_W-1:0] rf_err_cnt_o,
    output logic [14:0]      mem_err_sticky_o,
    output logic [2:0]       rf_err_sticky_o,
    output logic             alarm_req_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALARM = 2'd1,
        HOLD  = 2'd2
    } alarmState_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_THR = CNT_W'(THRESHOLD);

    logic [DIV_W-1:0] s1Div0_q;
    logic [DIV_W-1:0] s1Div1_q;
    logic [DIV_W-1:0] s1Div2_q;
    logic [14:0]      s1MemErr_q;
    logic [2:0]       s1RfErr_q;

    logic [DIV_W-1:0] voted_d;
    logic [DIV_W-1:0] voted_q;
    logic [2:0]       laneDis_d;
    logic [2:0]       laneDis_q;
    logic             mismatch_d;
    logic             mismatch_q;
    logic             singleEvt_d;
    logic             singleEvt_q;
    logic             uncorrEvt_d;
    logic             uncorrEvt_q;
    logic [14:0]      s2MemErr_q;
    logic [2:0]       s2RfErr_q;

    logic [CNT_W-1:0] divCorrCnt_d;
    logic [CNT_W-1:0] divCorrCnt_q;
    logic [CNT_W-1:0] memErrCnt_d;
    logic [CNT_W-1:0] memErrCnt_q;
    logic [CNT_W-1:0] rfErrCnt_d;
    logic [CNT_W-1:0] rfErrCnt_q;
    logic [2:0]       faultyLane_d;
    logic [2:0]       faultyLane_q;
    logic             divUncorr_d;
    logic             divUncorr_q;
    logic [14:0]      memSticky_d;
    logic [14:0]      memSticky_q;
    logic [2:0]       rfSticky_d;
    logic [2:0]       rfSticky_q;

    logic             alarmCond;
    alarmState_e      state_d;
    alarmState_e      state_q;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1Div0_q   <= '0;
            s1Div1_q   <= '0;
            s1Div2_q   <= '0;
            s1MemErr_q <= '0;
            s1RfErr_q  <= '0;
        end else begin
            s1Div0_q   <= div_in_0_i;
            s1Div1_q   <= div_in_1_i;
            s1Div2_q   <= div_in_2_i;
            s1MemErr_q <= mem_err_i;
            s1RfErr_q  <= rf_err_i;
        end
    end

    // Any two lanes agreeing on a bit decide it; a lane is faulty when its word differs from the vote.
    always_comb begin
        voted_d      = (s1Div0_q & s1Div1_q) | (s1Div0_q & s1Div2_q) | (s1Div1_q & s1Div2_q);
        laneDis_d[0] = (s1Div0_q != voted_d);
        laneDis_d[1] = (s1Div1_q != voted_d);
        laneDis_d[2] = (s1Div2_q != voted_d);
        mismatch_d   = |laneDis_d;
        singleEvt_d  = (laneDis_d == 3'b001) || (laneDis_d == 3'b010) || (laneDis_d == 3'b100);
        uncorrEvt_d  = (s1Div0_q != s1Div1_q) && (s1Div1_q != s1Div2_q) && (s1Div0_q != s1Div2_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            voted_q     <= '0;
            laneDis_q   <= '0;
            mismatch_q  <= 1'b0;
            singleEvt_q <= 1'b0;
            uncorrEvt_q <= 1'b0;
            s2MemErr_q  <= '0;
            s2RfErr_q   <= '0;
        end else begin
            voted_q     <= voted_d;
            laneDis_q   <= laneDis_d;
            mismatch_q  <= mismatch_d;
            singleEvt_q <= singleEvt_d;
            uncorrEvt_q <= uncorrEvt_d;
            s2MemErr_q  <= s1MemErr_q;
            s2RfErr_q   <= s1RfErr_q;
        end
    end

    // Clear wins over any event landing in the same cycle, so that event is simply lost.
    always_comb begin
        divCorrCnt_d = divCorrCnt_q;
        memErrCnt_d  = memErrCnt_q;
        rfErrCnt_d   = rfErrCnt_q;
        faultyLane_d = faultyLane_q;
        divUncorr_d  = divUncorr_q;
        memSticky_d  = memSticky_q;
        rfSticky_d   = rfSticky_q;
        if (clear_i) begin
            divCorrCnt_d = '0;
            memErrCnt_d  = '0;
            rfErrCnt_d   = '0;
            faultyLane_d = '0;
            divUncorr_d  = 1'b0;
            memSticky_d  = '0;
            rfSticky_d   = '0;
        end else if (enable_i) begin
            if (singleEvt_q) begin
                divCorrCnt_d = satInc(divCorrCnt_q);
                faultyLane_d = faultyLane_q | laneDis_q;
            end
            if (uncorrEvt_q) begin
                divUncorr_d  = 1'b1;
                faultyLane_d = 3'b111;
            end
            if (|s2MemErr_q) begin
                memErrCnt_d = satInc(memErrCnt_q);
                memSticky_d = memSticky_q | s2MemErr_q;
            end
            if (|s2RfErr_q) begin
                rfErrCnt_d = satInc(rfErrCnt_q);
                rfSticky_d = rfSticky_q | s2RfErr_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            divCorrCnt_q <= '0;
            memErrCnt_q  <= '0;
            rfErrCnt_q   <= '0;
            faultyLane_q <= '0;
            divUncorr_q  <= 1'b0;
            memSticky_q  <= '0;
            rfSticky_q   <= '0;
        end else begin
            divCorrCnt_q <= divCorrCnt_d;
            memErrCnt_q  <= memErrCnt_d;
            rfErrCnt_q   <= rfErrCnt_d;
            faultyLane_q <= faultyLane_d;
            divUncorr_q  <= divUncorr_d;
            memSticky_q  <= memSticky_d;
            rfSticky_q   <= rfSticky_d;
        end
    end

    assign alarmCond = divUncorr_q
                    || (divCorrCnt_q >= CNT_THR)
                    || (memErrCnt_q >= CNT_THR)
                    || (rfErrCnt_q >= CNT_THR)
                    || (|rfSticky_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // HOLD is only left through clear, so one fault episode raises exactly one alarm.
    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (alarmCond) state_d = ALARM;
                ALARM:   if (alarm_ack_i) state_d = HOLD;
                HOLD:    state_d = HOLD;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        alarm_req_o = 1'b0;
        if (state_q == ALARM) begin
            alarm_req_o = 1'b1;
        end
    end

    assign voted_o          = voted_q;
    assign div_mismatch_o   = mismatch_q;
    assign faulty_lane_o    = faultyLane_q;
    assign div_uncorr_o     = divUncorr_q;
    assign div_corr_cnt_o   = divCorrCnt_q;
    assign mem_err_cnt_o    = memErrCnt_q;
    assign rf_err_cnt_o     = rfErrCnt_q;
    assign mem_err_sticky_o = memSticky_q;
    assign rf_err_sticky_o  = rfSticky_q;

endmodule

// File: tb/tb_cv32e40p_fault_monitor.sv
// Bench for cv32e40p_fault_monitor: a cycle model derived from the behavioural rules is compared
// against the DUT every cycle, alongside directed scenarios with hand-computed expectations.
module tb_cv32e40p_fault_monitor;

    localparam int CNT_W     = 4;
    localparam int THRESHOLD = 4;
    localparam int DIV_W     = 33;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             enable = 1'b0;
    logic [DIV_W-1:0] div0 = '0;
    logic [DIV_W-1:0] div1 = '0;
    logic [DIV_W-1:0] div2 = '0;
    logic [14:0]      memErr = '0;
    logic [2:0]       rfErr = '0;
    logic             clear = 1'b0;
    logic             ack = 1'b0;

    logic [DIV_W-1:0] voted;
    logic             mismatch;
    logic [2:0]       faulty;
    logic             uncorr;
    logic [CNT_W-1:0] corrCnt;
    logic [CNT_W-1:0] memCnt;
    logic [CNT_W-1:0] rfCnt;
    logic [14:0]      memSticky;
    logic [2:0]       rfSticky;
    logic             alarmReq;

    always #5 clk = ~clk;

    cv32e40p_fault_monitor #(
        .CNT_W    (CNT_W),
        .THRESHOLD(THRESHOLD),
        .DIV_W    (DIV_W)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .enable_i        (enable),
        .div_in_0_i      (div0),
        .div_in_1_i      (div1),
        .div_in_2_i      (div2),
        .mem_err_i       (memErr),
        .rf_err_i        (rfErr),
        .clear_i         (clear),
        .alarm_ack_i     (ack),
        .voted_o         (voted),
        .div_mismatch_o  (mismatch),
        .faulty_lane_o   (faulty),
        .div_uncorr_o    (uncorr),
        .div_corr_cnt_o  (corrCnt),
        .mem_err_cnt_o   (memCnt),
        .rf_err_cnt_o    (rfCnt),
        .mem_err_sticky_o(memSticky),
        .rf_err_sticky_o (rfSticky),
        .alarm_req_o     (alarmReq)
    );

    typedef struct packed {
        logic [DIV_W-1:0] d0;
        logic [DIV_W-1:0] d1;
        logic [DIV_W-1:0] d2;
        logic [14:0]      mem;
        logic [2:0]       rf;
    } rec_t;

    int errors = 0;
    int checks = 0;
    bit checkEn = 1'b0;

    logic [DIV_W-1:0] expVoted = '0;
    bit               expMismatch = 1'b0;
    logic [2:0]       expFaulty = '0;
    bit               expUncorr = 1'b0;
    int               expCorr = 0;
    int               expMem = 0;
    int               expRf = 0;
    logic [14:0]      expMemSticky = '0;
    logic [2:0]       expRfSticky = '0;
    bit               expReq = 1'b0;
    bit               raised = 1'b0;
    rec_t             p1 = '0;
    rec_t             p2 = '0;

    function automatic logic [DIV_W-1:0] majorityOf(input rec_t r);
        logic [DIV_W-1:0] m;
        m = '0;
        for (int b = 0; b < DIV_W; b++) begin
            int ones;
            ones = int'(r.d0[b]) + int'(r.d1[b]) + int'(r.d2[b]);
            m[b] = (ones >= 2);
        end
        return m;
    endfunction

    function automatic logic [2:0] disagreeMask(input rec_t r);
        logic [DIV_W-1:0] m;
        m = majorityOf(r);
        return {r.d2 != m, r.d1 != m, r.d0 != m};
    endfunction

    function automatic int satInc(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    // Expected register contents after each rising edge; a record reaches bookkeeping two edges after capture.
    task automatic modelStep();
        rec_t     cur;
        logic [2:0] dm;
        bit       cond;
        cur  = {div0, div1, div2, memErr, rfErr};
        cond = expUncorr || (expCorr >= THRESHOLD) || (expMem >= THRESHOLD)
            || (expRf >= THRESHOLD) || (expRfSticky != 3'b000);
        if (rst) begin
            expVoted = '0; expMismatch = 1'b0; expFaulty = '0; expUncorr = 1'b0;
            expCorr = 0; expMem = 0; expRf = 0; expMemSticky = '0; expRfSticky = '0;
            expReq = 1'b0; raised = 1'b0; p1 = '0; p2 = '0;
            return;
        end
        if (clear) begin
            expFaulty = '0; expUncorr = 1'b0; expCorr = 0; expMem = 0; expRf = 0;
            expMemSticky = '0; expRfSticky = '0; expReq = 1'b0; raised = 1'b0;
        end else begin
            if (enable) begin
                dm = disagreeMask(p2);
                if ($countones(dm) == 1) begin
                    expCorr   = satInc(expCorr);
                    expFaulty = expFaulty | dm;
                end
                if (p2.d0 != p2.d1 && p2.d1 != p2.d2 && p2.d0 != p2.d2) begin
                    expUncorr = 1'b1;
                    expFaulty = 3'b111;
                end
                if (p2.mem != 15'h0) begin
                    expMem       = satInc(expMem);
                    expMemSticky = expMemSticky | p2.mem;
                end
                if (p2.rf != 3'h0) begin
                    expRf       = satInc(expRf);
                    expRfSticky = expRfSticky | p2.rf;
                end
            end
            if (expReq) begin
                if (ack) expReq = 1'b0;
            end else if (!raised && cond) begin
                expReq = 1'b1;
                raised = 1'b1;
            end
        end
        expVoted    = majorityOf(p1);
        expMismatch = (disagreeMask(p1) != 3'b000);
        p2 = p1;
        p1 = cur;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic compareAll();
        checkOutput("m_voted", 64'(voted), 64'(expVoted));
        checkOutput("m_mismatch", 64'(mismatch), 64'(expMismatch));
        checkOutput("m_faulty", 64'(faulty), 64'(expFaulty));
        checkOutput("m_uncorr", 64'(uncorr), 64'(expUncorr));
        checkOutput("m_corr_cnt", 64'(corrCnt), 64'(expCorr));
        checkOutput("m_mem_cnt", 64'(memCnt), 64'(expMem));
        checkOutput("m_rf_cnt", 64'(rfCnt), 64'(expRf));
        checkOutput("m_mem_sticky", 64'(memSticky), 64'(expMemSticky));
        checkOutput("m_rf_sticky", 64'(rfSticky), 64'(expRfSticky));
        checkOutput("m_alarm", 64'(alarmReq), 64'(expReq));
    endtask

    initial forever begin
        @(posedge clk);
        modelStep();
    end

    initial forever begin
        @(negedge clk);
        if (checkEn) compareAll();
    end

    task automatic applyStimulus(input logic [DIV_W-1:0] a, input logic [DIV_W-1:0] b,
                                 input logic [DIV_W-1:0] c, input logic [14:0] m,
                                 input logic [2:0] r, input logic en, input logic clr,
                                 input logic ak);
        @(negedge clk);
        div0 = a; div1 = b; div2 = c;
        memErr = m; rfErr = r;
        enable = en; clear = clr; ack = ak;
    endtask

    task automatic idleCycles(input int n, input logic en, input logic ak);
        for (int i = 0; i < n; i++) begin
            applyStimulus('0, '0, '0, 15'h0, 3'h0, en, 1'b0, ak);
        end
    endtask

    task automatic clearPulse();
        applyStimulus('0, '0, '0, 15'h0, 3'h0, 1'b1, 1'b1, 1'b0);
        idleCycles(1, 1'b1, 1'b0);
    endtask

    initial begin
        bit seen;
        int highCycles;

        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            div0   = DIV_W'({$urandom(), $urandom()});
            div1   = DIV_W'({$urandom(), $urandom()});
            div2   = DIV_W'({$urandom(), $urandom()});
            memErr = 15'($urandom());
            rfErr  = 3'($urandom());
            enable = 1'b1;
            clear  = 1'($urandom());
            ack    = 1'($urandom());
        end
        @(negedge clk);
        checkOutput("rst_voted", 64'(voted), 64'h0);
        checkOutput("rst_mismatch", 64'(mismatch), 64'h0);
        checkOutput("rst_faulty", 64'(faulty), 64'h0);
        checkOutput("rst_uncorr", 64'(uncorr), 64'h0);
        checkOutput("rst_corr_cnt", 64'(corrCnt), 64'h0);
        checkOutput("rst_mem_cnt", 64'(memCnt), 64'h0);
        checkOutput("rst_rf_cnt", 64'(rfCnt), 64'h0);
        checkOutput("rst_mem_sticky", 64'(memSticky), 64'h0);
        checkOutput("rst_rf_sticky", 64'(rfSticky), 64'h0);
        checkOutput("rst_alarm", 64'(alarmReq), 64'h0);
        rst = 1'b0; enable = 1'b1; clear = 1'b0; ack = 1'b0;
        div0 = '0; div1 = '0; div2 = '0; memErr = '0; rfErr = '0;
        checkEn = 1'b1;

        $display("[TB] correctable vote");
        applyStimulus(33'h5, 33'h5, 33'h7, 15'h0, 3'h0, 1'b1, 1'b0, 1'b0);
        idleCycles(2, 1'b1, 1'b0);
        checkOutput("corr_voted", 64'(voted), 64'h5);
        checkOutput("corr_mismatch", 64'(mismatch), 64'h1);
        idleCycles(1, 1'b1, 1'b0);
        checkOutput("corr_cnt", 64'(corrCnt), 64'h1);
        checkOutput("corr_lane", 64'(faulty), 64'h4);
        checkOutput("corr_mismatch_gone", 64'(mismatch), 64'h0);

        $display("[TB] threshold alarm");
        clearPulse();
        for (int i = 0; i < 4; i++) applyStimulus(33'h9, 33'h8, 33'h9, 15'h0, 3'h0, 1'b1, 1'b0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            idleCycles(1, 1'b1, 1'b0);
            if (alarmReq) seen = 1'b1;
        end
        checkOutput("thr_alarm_rise", 64'(seen), 64'h1);
        checkOutput("thr_corr_cnt", 64'(corrCnt), 64'h4);
        checkOutput("thr_lane", 64'(faulty), 64'h2);
        for (int i = 0; i < 5; i++) begin
            idleCycles(1, 1'b1, 1'b0);
            checkOutput("thr_alarm_held", 64'(alarmReq), 64'h1);
        end
        idleCycles(1, 1'b1, 1'b1);
        idleCycles(1, 1'b1, 1'b0);
        checkOutput("thr_alarm_acked", 64'(alarmReq), 64'h0);
        applyStimulus(33'h9, 33'h8, 33'h9, 15'h0, 3'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            idleCycles(1, 1'b1, 1'b0);
            checkOutput("thr_no_realarm", 64'(alarmReq), 64'h0);
        end
        checkOutput("thr_corr_cnt5", 64'(corrCnt), 64'h5);
        clearPulse();
        checkOutput("thr_clr_cnt", 64'(corrCnt), 64'h0);
        checkOutput("thr_clr_lane", 64'(faulty), 64'h0);
        checkOutput("thr_clr_alarm", 64'(alarmReq), 64'h0);

        $display("[TB] uncorrectable with ack held high");
        applyStimulus(33'h1, 33'h2, 33'h4, 15'h0, 3'h0, 1'b1, 1'b0, 1'b0);
        highCycles = 0;
        for (int i = 0; i < 8; i++) begin
            idleCycles(1, 1'b1, 1'b1);
            if (alarmReq) highCycles++;
        end
        checkOutput("unc_alarm_cycles", 64'(highCycles), 64'h1);
        checkOutput("unc_flag", 64'(uncorr), 64'h1);
        checkOutput("unc_lanes", 64'(faulty), 64'h7);
        checkOutput("unc_corr_cnt", 64'(corrCnt), 64'h0);
        clearPulse();

        $display("[TB] error flags and enable");
        applyStimulus('0, '0, '0, 15'h0001, 3'h0, 1'b1, 1'b0, 1'b0);
        applyStimulus('0, '0, '0, 15'h4000, 3'h0, 1'b1, 1'b0, 1'b0);
        idleCycles(2, 1'b1, 1'b0);
        applyStimulus('0, '0, '0, 15'h0002, 3'h0, 1'b0, 1'b0, 1'b0);
        idleCycles(3, 1'b0, 1'b0);
        idleCycles(2, 1'b1, 1'b0);
        checkOutput("flg_mem_cnt", 64'(memCnt), 64'h2);
        checkOutput("flg_mem_sticky", 64'(memSticky), 64'h4001);
        applyStimulus('0, '0, '0, 15'h0, 3'b010, 1'b1, 1'b0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            idleCycles(1, 1'b1, 1'b0);
            if (alarmReq) seen = 1'b1;
        end
        checkOutput("flg_rf_alarm", 64'(seen), 64'h1);
        checkOutput("flg_rf_sticky", 64'(rfSticky), 64'h2);
        checkOutput("flg_rf_cnt", 64'(rfCnt), 64'h1);
        idleCycles(1, 1'b1, 1'b1);
        clearPulse();

        $display("[TB] saturation and clear collision");
        for (int i = 0; i < 20; i++) applyStimulus('0, '0, '0, 15'h0001, 3'h0, 1'b1, 1'b0, 1'b0);
        idleCycles(3, 1'b1, 1'b0);
        checkOutput("sat_mem_cnt", 64'(memCnt), 64'(CNT_MAX));
        clearPulse();
        applyStimulus(33'h9, 33'h8, 33'h9, 15'h0001, 3'h0, 1'b1, 1'b0, 1'b0);
        applyStimulus(33'h1_0000_0006, 33'h1_0000_0006, 33'h1_0000_0006, 15'h0, 3'h0, 1'b1, 1'b0, 1'b0);
        applyStimulus('0, '0, '0, 15'h0, 3'h0, 1'b1, 1'b1, 1'b0);
        idleCycles(1, 1'b1, 1'b0);
        checkOutput("col_mem_cnt", 64'(memCnt), 64'h0);
        checkOutput("col_corr_cnt", 64'(corrCnt), 64'h0);
        checkOutput("col_mem_sticky", 64'(memSticky), 64'h0);
        checkOutput("col_lane", 64'(faulty), 64'h0);
        checkOutput("col_voted_kept", 64'(voted), 64'h1_0000_0006);
        idleCycles(1, 1'b1, 1'b0);
        checkOutput("col_mem_cnt_late", 64'(memCnt), 64'h0);
        checkOutput("col_corr_cnt_late", 64'(corrCnt), 64'h0);
        idleCycles(2, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
